// File: rtl/withdraw_if.sv
// Handshake and data bundle between the menu FSM (master) and the balance
// sequencer (slave).
interface withdraw_if #(
  parameter int W     = 5,
  parameter int CNT_W = 4
);
  logic             start;
  logic             op;
  logic [W-1:0]     val;
  logic             load;
  logic [W-1:0]     load_val;
  logic [W-1:0]     bal;
  logic             busy;
  logic             done;
  logic             ok;
  logic             err;
  logic [CNT_W-1:0] tx_cnt;

  modport master (
    output start, op, val, load, load_val,
    input  bal, busy, done, ok, err, tx_cnt
  );

  modport slave (
    input  start, op, val, load, load_val,
    output bal, busy, done, ok, err, tx_cnt
  );
endinterface

// File: rtl/withdraw_ctrl.sv
// ATM balance sequencer: multi-cycle deposit/withdraw with funds and overflow
// checking, reported through a START/BUSY/DONE handshake.
module withdraw_ctrl #(
  parameter int           W        = 5,
  parameter logic [W-1:0] INIT_BAL = '0,
  parameter int           CNT_W    = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  withdraw_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COMP, ADD, CHECK, FIN} state_t;

  state_t           state_q,  state_d;
  logic [W-1:0]     bal_q,    bal_d;
  logic [W-1:0]     opr_q,    opr_d;
  logic             ops_q,    ops_d;
  logic             cin_q,    cin_d;
  logic [W:0]       sum_q,    sum_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             ok_q,     ok_d;
  logic             err_q,    err_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             pass;

  // Withdraw passes on carry out (no borrow); deposit passes when there is none.
  assign pass = ops_q ? sum_q[W] : ~sum_q[W];

  always_comb begin
    state_d  = state_q;
    bal_d    = bal_q;
    opr_d    = opr_q;
    ops_d    = ops_q;
    cin_d    = cin_q;
    sum_d    = sum_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    err_d    = err_q;
    tx_cnt_d = tx_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          bal_d = bus.load_val;
        end else if (bus.start) begin
          opr_d   = bus.val;
          ops_d   = bus.op;
          ok_d    = 1'b0;
          err_d   = 1'b0;
          state_d = COMP;
        end
      end
      COMP: begin
        opr_d   = ops_q ? ~opr_q : opr_q;
        cin_d   = ops_q;
        state_d = ADD;
      end
      ADD: begin
        sum_d   = {1'b0, bal_q} + {1'b0, opr_q} + {{W{1'b0}}, cin_q};
        state_d = CHECK;
      end
      CHECK: begin
        if (pass) begin
          bal_d    = sum_q[W-1:0];
          ok_d     = 1'b1;
          tx_cnt_d = tx_cnt_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bal_q    <= INIT_BAL;
      opr_q    <= '0;
      ops_q    <= 1'b0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bal_q    <= bal_d;
      opr_q    <= opr_d;
      ops_q    <= ops_d;
      cin_q    <= cin_d;
      sum_q    <= sum_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign bus.bal    = bal_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ok     = ok_q;
  assign bus.err    = err_q;
  assign bus.tx_cnt = tx_cnt_q;

endmodule

// File: tb/tb_withdraw_ctrl.sv
// Self-checking bench for withdraw_ctrl: directed scenarios plus randomized
// transactions against an arithmetic model of the account.
module tb_withdraw_ctrl;
  localparam int W     = 5;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << W) - 1;
  localparam int CMOD  = 1 << CNT_W;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  int   m_bal;
  int   m_tx;
  int   m_ok;
  int   m_err;

  withdraw_if #(.W(W), .CNT_W(CNT_W)) bus ();

  withdraw_ctrl #(.W(W), .INIT_BAL(5'd0), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_bal"}, int'(bus.bal), m_bal);
    chk({tag, "_ok"},  int'(bus.ok), m_ok);
    chk({tag, "_err"}, int'(bus.err), m_err);
    chk({tag, "_tx"},  int'(bus.tx_cnt), m_tx);
  endtask

  // One full transaction; with junk set, inputs are scrambled while busy.
  task automatic do_tx(input int op, input int v, input bit junk);
    int n;
    bit pass;
    if (op != 0) pass = (m_bal >= v);
    else         pass = (m_bal + v <= MAXV);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = (op != 0);
    bus.val   = W'(v);
    bus.load  = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_rise", int'(bus.busy), 1);
    chk("ok_clr", int'(bus.ok), 0);
    chk("err_clr", int'(bus.err), 0);
    n = 0;
    while (!bus.done && n < 10) begin
      if (junk) begin
        bus.start    = 1'($urandom);
        bus.load     = 1'($urandom);
        bus.load_val = W'($urandom);
        bus.val      = W'($urandom);
        bus.op       = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    bus.load  = 1'b0;
    if (pass) begin
      m_bal = (op != 0) ? m_bal - v : m_bal + v;
      m_tx  = (m_tx + 1) % CMOD;
      m_ok  = 1;
      m_err = 0;
    end else begin
      m_ok  = 0;
      m_err = 1;
    end
    chk("done_latency", n, 3);
    chk("busy_at_done", int'(bus.busy), 1);
    chk_state("tx");
    @(posedge clk); #1;
    chk("done_pulse", int'(bus.done), 0);
    chk("busy_fall", int'(bus.busy), 0);
  endtask

  task automatic do_load(input int v, input bit with_start);
    @(negedge clk);
    bus.load     = 1'b1;
    bus.load_val = W'(v);
    bus.start    = with_start;
    bus.op       = 1'b1;
    bus.val      = W'(1);
    @(posedge clk); #1;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    m_bal = v;
    chk("load_busy", int'(bus.busy), 0);
    chk_state("load");
    @(posedge clk); #1;
    chk("load_nobusy", int'(bus.busy), 0);
    chk("load_nodone", int'(bus.done), 0);
  endtask

  task automatic model_reset();
    m_bal = 0;
    m_tx  = 0;
    m_ok  = 0;
    m_err = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_done;
    checks   = 0;
    failures = 0;
    model_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 1'b0;
    bus.val      = '0;
    bus.load     = 1'b0;
    bus.load_val = '0;

    // Reset values
    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD 20, withdraw 7
    do_load(20, 1'b0);
    do_tx(1, 7, 1'b0);
    chk("w7_bal13", int'(bus.bal), 13);
    chk("w7_tx1", int'(bus.tx_cnt), 1);

    // Insufficient funds, then exact withdraw
    do_tx(1, 14, 1'b0);
    chk("w14_err", int'(bus.err), 1);
    chk("w14_bal", int'(bus.bal), 13);
    do_tx(1, 13, 1'b0);
    chk("w13_bal0", int'(bus.bal), 0);

    // Deposit to the top, overflow, withdraw zero
    do_load(13, 1'b0);
    do_tx(0, 18, 1'b0);
    chk("d18_bal31", int'(bus.bal), 31);
    do_tx(0, 1, 1'b0);
    chk("d1_err", int'(bus.err), 1);
    do_tx(1, 0, 1'b0);
    chk("w0_ok", int'(bus.ok), 1);
    chk("w0_bal31", int'(bus.bal), 31);

    // Inputs during BUSY are ignored; LOAD beats START
    do_tx(1, 5, 1'b1);
    do_load(9, 1'b1);

    // Reset while in ADD aborts the transaction
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.val   = W'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk_state("abort");
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1;
    end
    chk("abort_nodone", seen_done, 0);
    chk("abort_bal", int'(bus.bal), 0);

    // Counter wrap
    for (int i = 0; i < CMOD; i++) do_tx(0, 0, 1'b0);
    chk("tx_wrap", int'(bus.tx_cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) do_load(int'($urandom_range(0, MAXV)), 1'($urandom));
      else do_tx(int'($urandom_range(0, 1)), int'($urandom_range(0, MAXV)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
